// File: rtl/timer_pkg.sv
// Shared types and defaults for the down_timer block.
package timer_pkg;

    localparam int unsigned TIMER_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } timer_state_t;

endpackage

// File: rtl/timer_ctrl_fsm.sv
// Control FSM for down_timer: state register, datapath strobes and the registered tc pulse.
// DOWN_TIMER_AUTO_RELOAD_EN: reaching zero in RUN reloads and keeps running instead of parking in DONE.
module timer_ctrl_fsm
    import timer_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic         i_start,
    input  logic         i_stop,
    input  logic         i_en,
    input  logic         i_cnt_is_zero,
    input  logic         i_cnt_is_one,
    output timer_state_t o_state,
    output logic         o_dec,
    output logic         o_reload,
    output logic         o_tc_set
);

    timer_state_t r_state;
    logic         r_tc;
    logic         w_dec;
    logic         w_hit_zero;
    logic         w_can_start;

    always_comb begin
        w_dec       = (r_state == RUN) && !i_stop && i_en && !i_cnt_is_zero;
        w_hit_zero  = w_dec && i_cnt_is_one;
        // A load in any non-RUN state takes priority over start on the same edge.
        w_can_start = i_start && !i_load && !i_cnt_is_zero;
    end

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_state <= IDLE;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= w_hit_zero;
            case (r_state)
                IDLE, DONE: begin
                    if (w_can_start) r_state <= RUN;
                end
                RUN: begin
                    if (i_stop) begin
                        r_state <= PAUSE;
                    end else if (w_hit_zero) begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                        r_state <= RUN;
`else
                        r_state <= DONE;
`endif
                    end
                end
                PAUSE: begin
                    if (w_can_start && !i_stop) r_state <= RUN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_state  = r_state;
        o_tc_set = r_tc;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        o_reload = w_hit_zero;
        o_dec    = w_dec && !w_hit_zero;
`else
        o_reload = 1'b0;
        o_dec    = w_dec;
`endif
    end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with start/stop/pause and a one-cycle terminal-count pulse.
// DOWN_TIMER_AUTO_RELOAD_EN: periodic mode, count reloads from the last loaded period at zero.
module down_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_W
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_out,
    output logic             o_tc,
    output logic             o_busy
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_reload;
    timer_state_t     w_state;
    logic             w_dec;
    logic             w_reload;
    logic             w_tc;
    logic             w_is_zero;
    logic             w_is_one;
    logic             w_load_ok;

    always_comb begin
        w_is_zero = (r_out == '0);
        w_is_one  = (r_out == WIDTH'(1));
        w_load_ok = i_load && (w_state != RUN);
    end

    timer_ctrl_fsm u_fsm (
        .i_clk         (i_clk),
        .i_clr         (i_clr),
        .i_load        (i_load),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_en          (i_en),
        .i_cnt_is_zero (w_is_zero),
        .i_cnt_is_one  (w_is_one),
        .o_state       (w_state),
        .o_dec         (w_dec),
        .o_reload      (w_reload),
        .o_tc_set      (w_tc)
    );

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_out    <= '0;
            r_reload <= '0;
        end else if (w_load_ok) begin
            r_out    <= i_load_val;
            r_reload <= i_load_val;
        end else if (w_reload) begin
            r_out <= r_reload;
        end else if (w_dec) begin
            r_out <= r_out - WIDTH'(1);
        end
    end

    always_comb begin
        o_out  = r_out;
        o_tc   = w_tc;
        o_busy = (w_state == RUN) || (w_state == PAUSE);
    end

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: directed scenarios plus random traffic against a behavioural model.
module tb_down_timer;

    localparam int W = 4;

    logic         clk;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         en;
    logic [W-1:0] out;
    logic         tc;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // Reference model: count value, remembered period, tc pulse and a mode word
    // (0 idle, 1 counting, 2 paused, 3 expired).
    int m_cnt  = 0;
    int m_per  = 0;
    int m_tc   = 0;
    int m_mode = 0;

    down_timer #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_clr      (clr),
        .i_load     (load),
        .i_load_val (load_val),
        .i_start    (start),
        .i_stop     (stop),
        .i_en       (en),
        .o_out      (out),
        .o_tc       (tc),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int c, input int l, input int lv, input int s,
                              input int p, input int e);
        if (c == 0) begin
            m_cnt = 0; m_per = 0; m_tc = 0; m_mode = 0;
            return;
        end
        m_tc = 0;
        if (m_mode == 1) begin
            if (p != 0) m_mode = 2;
            else if (e != 0) begin
                if (m_cnt == 1) begin
                    m_tc = 1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                    m_cnt = m_per;
`else
                    m_cnt = 0;
                    m_mode = 3;
`endif
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end else if (l != 0) begin
            m_cnt = lv;
            m_per = lv;
        end else if (s != 0 && m_cnt != 0 && !(m_mode == 2 && p != 0)) begin
            m_mode = 1;
        end
    endtask

    // Apply one cycle of inputs, clock it, and compare all outputs against the model.
    task automatic step(input string tag, input int c, input int l, input int lv,
                        input int s, input int p, input int e);
        clr = c[0]; load = l[0]; load_val = W'(lv); start = s[0]; stop = p[0]; en = e[0];
        @(posedge clk);
        model_edge(c, l, lv, s, p, e);
        #1;
        check_eq({tag, "_out"}, 32'(out), 32'(m_cnt));
        check_eq({tag, "_tc"}, 32'(tc), 32'(m_tc));
        check_eq({tag, "_busy"}, 32'(busy), 32'((m_mode == 1 || m_mode == 2) ? 1 : 0));
        @(negedge clk);
    endtask

    initial begin
        int tc_seen;
        clr = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; en = 1'b0;
        @(negedge clk);

        step("rst", 0, 1, 7, 1, 0, 1);
        check_eq("rst_out_zero", 32'(out), 32'd0);

`ifndef DOWN_TIMER_AUTO_RELOAD_EN
        // Load 5, start, count to zero and park in DONE.
        step("t1_ld", 1, 1, 5, 0, 0, 0);
        step("t1_st", 1, 0, 0, 1, 0, 1);
        check_eq("t1_no_dec_on_start", 32'(out), 32'd5);
        tc_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step("t1_run", 1, 0, 0, 0, 0, 1);
            tc_seen += int'(tc);
        end
        check_eq("t1_final_out", 32'(out), 32'd0);
        check_eq("t1_tc_count", 32'(tc_seen), 32'd1);
        step("t1_done", 1, 0, 0, 0, 0, 1);
        check_eq("t1_tc_one_cycle", 32'(tc), 32'd0);
        check_eq("t1_idle_busy", 32'(busy), 32'd0);

        // Load 9, run 3, pause 4 (with en high), resume to zero.
        step("t2_ld", 1, 1, 9, 0, 0, 0);
        step("t2_st", 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step("t2_run", 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("t2_stop", 1, 0, 0, 0, 1, 1);
        check_eq("t2_pause_hold", 32'(out), 32'd6);
        check_eq("t2_pause_busy", 32'(busy), 32'd1);
        step("t2_resume", 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) step("t2_run2", 1, 0, 0, 0, 0, 1);
        check_eq("t2_tc", 32'(tc), 32'd1);

        // Load 4, en toggling.
        step("t3_ld", 1, 1, 4, 0, 0, 0);
        step("t3_st", 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step("t3_tog", 1, 0, 0, 0, 0, (i % 2 == 0) ? 1 : 0);
        check_eq("t3_out", 32'(out), 32'd0);

        // Load 12, reset mid-count, start with zero ignored.
        step("t4_ld", 1, 1, 12, 0, 0, 0);
        step("t4_st", 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) step("t4_run", 1, 0, 0, 0, 0, 1);
        step("t4_clr", 0, 0, 0, 0, 0, 1);
        step("t4_st0", 1, 0, 0, 1, 0, 1);
        check_eq("t4_ignored_busy", 32'(busy), 32'd0);

        // Collisions: start+load in IDLE, load during RUN, stop+start in PAUSE.
        step("t5_ldst", 1, 1, 8, 1, 0, 1);
        check_eq("t5_load_wins", 32'(busy), 32'd0);
        step("t5_st", 1, 0, 0, 1, 0, 0);
        step("t5_ldrun", 1, 1, 2, 0, 0, 1);
        check_eq("t5_load_ignored", 32'(out), 32'd7);
        step("t5_stop", 1, 0, 0, 0, 1, 1);
        step("t5_stst", 1, 0, 0, 1, 1, 1);
        check_eq("t5_stays_pause", 32'(out), 32'd7);
        step("t5_pld", 1, 1, 3, 0, 0, 1);
        check_eq("t5_pause_load", 32'(out), 32'd3);
`else
        // Periodic mode: period 3, tc every third enabled edge.
        step("ar_ld", 1, 1, 3, 0, 0, 0);
        step("ar_st", 1, 0, 0, 1, 0, 1);
        tc_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step("ar_run", 1, 0, 0, 0, 0, 1);
            tc_seen += int'(tc);
        end
        check_eq("ar_tc_count", 32'(tc_seen), 32'd4);
        check_eq("ar_busy", 32'(busy), 32'd1);
        check_eq("ar_out", 32'(out), 32'd3);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int c, l, s, p, e;
            c = ($urandom_range(0, 63) == 0) ? 0 : 1;
            l = ($urandom_range(0, 7) == 0) ? 1 : 0;
            s = ($urandom_range(0, 3) == 0) ? 1 : 0;
            p = ($urandom_range(0, 9) == 0) ? 1 : 0;
            e = ($urandom_range(0, 3) != 0) ? 1 : 0;
            step("rnd", c, l, int'($urandom_range(0, 15)), s, p, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Synchronous, loadable down-counting timer; the count-down counterpart to the ripple up-counter.
- Software or upstream logic loads a period, starts it, and may pause and resume it.
- Asserts a one-cycle terminal-count pulse when the count reaches zero.
- Sits in the timer datapath as the event or timeout generator that downstream logic consumes.

Parameters:
- WIDTH, 4: counter and load-value width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- load  in  1  load request; captures load_val.
- load_val  in  WIDTH  period to load.
- start  in  1  start or resume request.
- stop  in  1  pause request.
- en  in  1  count-enable tick; decrement only when high.
- out  out  WIDTH  current count.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- busy  out  1  high while in RUN or PAUSE.

Behaviour:
- Reset: clr=0 at a clk edge gives out=0, internal reload_reg=0, state=IDLE, tc=0, busy=0. This overrides every other input, including mid-count. tc also drops on that same edge.
- State machine: states are IDLE, RUN, PAUSE, DONE.
  - IDLE/DONE + load=1: out<=load_val and reload_reg<=load_val. The state is unchanged.
  - IDLE/DONE + start=1 + out!=0 (with load=0): go to RUN. No decrement on this edge.
  - IDLE/DONE + start=1 + out==0: ignored; stay in the current state.
  - IDLE/DONE + load=1 + start=1 on the same edge: load wins; start is ignored.
  - RUN + stop=1: go to PAUSE. out holds and no decrement happens on this edge. stop wins over a simultaneous en.
  - RUN + stop=0 + en=1: out<=out-1.
  - RUN reaching zero: when out==1 and a decrement occurs, out<=0, tc<=1, and the state goes to DONE.
  - RUN + load=1: load is ignored while running.
  - PAUSE + load=1: out and reload_reg are loaded; the state stays PAUSE.
  - PAUSE + start=1 + stop=0 + out!=0: go to RUN.
  - PAUSE + start=1 + stop=1: stop wins; stay in PAUSE.
  - PAUSE + start=1 + out==0: ignored.
- tc: high only for the single cycle after the edge on which out becomes 0 (or reloads, with the optional feature). Otherwise 0.
- busy = (state==RUN) || (state==PAUSE), decoded from the registered state.
- Latency: load N, start sampled at edge k, en held at 1. Then out=N-j after edge k+j, and tc=1 during the cycle after edge k+N. Total N+1 edges from start to the tc pulse.
- No underflow: out never decrements below 0 and never wraps to 2^WIDTH-1.
- Maximum period: load_val = 2^WIDTH-1 (15 for WIDTH=4).
- en=0 in RUN: count holds and the state stays RUN.

Optional Feature:
- Macro: DOWN_TIMER_AUTO_RELOAD_EN.
- Defined: on the reaching-zero event in RUN, out<=reload_reg, tc<=1, and the state stays RUN. This gives a periodic tc every reload_reg enabled ticks. DONE is never entered from RUN. stop still pauses as normal.
- Undefined: one-shot behaviour as above; the timer parks in DONE with out=0.

Decomposition:
- Package timer_pkg holds:
  - typedef enum logic [1:0] timer_state_t {IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11};
  - localparam default width TIMER_W=4.
- Sub-module timer_ctrl_fsm holds the state register and next-state logic.
  - Inputs: clk, clr, start, stop, en, cnt_is_zero, cnt_is_one.
  - Outputs: state, dec, reload, tc_set.
- The counter/reload datapath stays in down_timer.

Test Plan (WIDTH=4):
- Reset, then load_val=5, load=1, then start=1 with en=1 -> out goes 5,4,3,2,1,0 on successive edges; tc=1 for exactly one cycle as out becomes 0; state=DONE; busy=0.
- load_val=9, start, en=1 for 3 edges, stop=1 for 4 edges, then start -> out holds at 6 during PAUSE with busy=1; resumes to 0; tc after a further 6 enabled edges.
- load_val=4, start, en toggling 1,0,1,0 -> decrement only on en=1 edges; tc after exactly 4 enabled edges.
- load_val=12, start, clr=0 after 5 edges -> next edge gives out=0, tc=0, busy=0, state=IDLE; a following start with out=0 is ignored.
- Simultaneous events: start+load in IDLE -> load wins, state stays IDLE. Load during RUN -> ignored, count unaffected. stop+start in PAUSE -> stays PAUSE.
- With DOWN_TIMER_AUTO_RELOAD_EN, load_val=3, en=1 for 12 edges -> tc pulses every 3rd edge (4 pulses); out sequence 3,2,1,3,2,1...; busy stays 1.
